// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: round-robin read arbitration and write priority for a shared sprite RAM
// Returns read data one-hot tagged to its requester; out-of-range reads return 0 with rsp_err.
module sprite_fetch_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 24,
    parameter int DEPTH   = 1601
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    input  logic                      wr_req,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ack,
    output logic                      wr_err,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_write_addr,
    output logic [DATA_W-1:0]         mem_data_in,
    output logic [ADDR_W-1:0]         mem_read_addr,
    input  logic [DATA_W-1:0]         mem_data_out
);
    localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    logic [IDX_W-1:0]   last, sel;
    logic               any, grant_en, sel_ok, wr_ok;
    logic [ADDR_W-1:0]  sel_addr;
    logic [NUM_REQ-1:0] tag1, tag2;
    logic               err1, err2;

    // Scan downward so the closest set bit after last wins; k = NUM_REQ revisits last itself.
    always_comb begin
        int j;
        j = 0;
        sel = last;
        any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(last) + k) % NUM_REQ;
            if (req[j]) begin
                sel = IDX_W'(j);
                any = 1'b1;
            end
        end
    end

    assign grant_en = any & ~wr_req;
    assign gnt      = grant_en ? (NUM_REQ'(1) << sel) : '0;
    assign sel_addr = req_addr[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_ok   = sel_addr < LIMIT;
    assign wr_ok    = wr_addr < LIMIT;
    assign wr_ack   = wr_req;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last           <= IDX_W'(NUM_REQ - 1);
            tag1           <= '0;
            tag2           <= '0;
            err1           <= 1'b0;
            err2           <= 1'b0;
            mem_read_addr  <= '0;
            mem_we         <= 1'b0;
            mem_write_addr <= '0;
            mem_data_in    <= '0;
            wr_err         <= 1'b0;
        end else begin
            if (grant_en) last <= sel;
            if (grant_en && sel_ok) mem_read_addr <= sel_addr;
            tag1   <= gnt;
            err1   <= grant_en & ~sel_ok;
            tag2   <= tag1;
            err2   <= err1;
            mem_we <= wr_req & wr_ok;
            wr_err <= wr_req & ~wr_ok;
            if (wr_req) begin
                mem_write_addr <= wr_addr;
                mem_data_in    <= wr_data;
            end
        end
    end

    assign rsp_valid = tag2;
    assign rsp_err   = err2 & |tag2;
    assign rsp_data  = (|tag2 && !err2) ? mem_data_out : '0;
endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// tb_sprite_fetch_arbiter: directed bench with an external RAM model and a response scoreboard
module tb_sprite_fetch_arbiter;
    localparam int AW = 19;
    localparam int DW = 24;
    localparam int DEPTH = 1601;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [3:0]    req = '0;
    logic [4*AW-1:0] req_addr = '0;
    logic [3:0]    gnt, rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack, wr_err, mem_we;
    logic [AW-1:0] mem_write_addr, mem_read_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic [3:0] tag;
        logic [DW-1:0] data;
        logic       err;
    } exp_t;
    exp_t q[$];

    logic [DW-1:0] ram [0:2047];
    logic [DW-1:0] ref_mem [0:2047];

    sprite_fetch_arbiter dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
        .mem_we(mem_we), .mem_write_addr(mem_write_addr), .mem_data_in(mem_data_in),
        .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Sprite RAM: separate write port, registered read
    always @(posedge Clk) begin
        if (mem_we) ram[mem_write_addr[10:0]] <= mem_data_in;
        mem_data_out <= ram[mem_read_addr[10:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(e.tag));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end else begin
            chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("idle_rsp_data", 64'(rsp_data), 64'(0));
            chk("idle_rsp_err", 64'(rsp_err), 64'(0));
        end
    end

    task automatic step(input logic [3:0] r, input logic [AW-1:0] a0, a1, a2, a3,
                        input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [3:0] eg);
        logic [AW-1:0] aa [4];
        exp_t e;
        aa = '{a0, a1, a2, a3};
        @(negedge Clk);
        req = r;
        req_addr = {a3, a2, a1, a0};
        wr_req = w;
        wr_addr = wa;
        wr_data = wd;
        #1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("wr_ack", 64'(wr_ack), 64'(w));
        if (w && wa < DEPTH) ref_mem[wa[10:0]] = wd;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                e.due  = cyc + 2;
                e.tag  = eg;
                e.err  = aa[i] >= DEPTH;
                e.data = e.err ? '0 : ref_mem[aa[i][10:0]];
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 0, 0, 0, 0, 1'b0, 0, 0, 4'b0000);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        step(4'b0000, 0, 0, 0, 0, 1'b1, wa, wd, 4'b0000);
    endtask

    initial begin
        #1 Reset = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("rst_gnt", 64'(gnt), 64'(0));
            chk("rst_wr_ack", 64'(wr_ack), 64'(0));
            chk("rst_mem_we", 64'(mem_we), 64'(0));
            chk("rst_mem_write_addr", 64'(mem_write_addr), 64'(0));
            chk("rst_mem_data_in", 64'(mem_data_in), 64'(0));
            chk("rst_mem_read_addr", 64'(mem_read_addr), 64'(0));
            chk("rst_wr_err", 64'(wr_err), 64'(0));
        end
        Reset = 1'b0;
        idle(2);
        chk("idle_mem_we", 64'(mem_we), 64'(0));
        chk("idle_wr_err", 64'(wr_err), 64'(0));
        chk("idle_mem_read_addr", 64'(mem_read_addr), 64'(0));

        wr(0, 24'h010101);
        wr(1, 24'h020202);
        wr(2, 24'h030303);
        wr(3, 24'h040404);
        wr(5, 24'hAABBCC);
        idle(1);

        // Four-way contention starting from the reset pointer
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b0001);
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b0010);
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b0100);
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b1000);
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b0001);
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b0010);
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b0100);
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b1000);
        idle(2);

        step(4'b0001, 5, 0, 0, 0, 1'b0, 0, 0, 4'b0001);
        idle(2);

        // Write blocks the read for one cycle, then the read sees the new data
        step(4'b0010, 0, 10, 0, 0, 1'b1, 10, 24'h123456, 4'b0000);
        step(4'b0010, 0, 10, 0, 0, 1'b0, 0, 0, 4'b0010);
        chk("mem_we_pulse", 64'(mem_we), 64'(1));
        chk("mem_write_addr", 64'(mem_write_addr), 64'(10));
        chk("mem_data_in", 64'(mem_data_in), 64'(24'h123456));
        idle(1);
        chk("mem_we_drop", 64'(mem_we), 64'(0));
        idle(1);

        // Out-of-range read and write
        step(4'b0100, 0, 0, 2000, 0, 1'b1, 1601, 24'hDEADBE, 4'b0000);
        step(4'b0100, 0, 0, 2000, 0, 1'b0, 0, 0, 4'b0100);
        chk("wr_err_pulse", 64'(wr_err), 64'(1));
        chk("oor_mem_we", 64'(mem_we), 64'(0));
        idle(1);
        chk("wr_err_drop", 64'(wr_err), 64'(0));
        chk("oor_mem_we_after", 64'(mem_we), 64'(0));
        idle(1);

        // Reset with two reads in flight
        step(4'b0011, 0, 1, 0, 0, 1'b0, 0, 0, 4'b0001);
        step(4'b0011, 0, 1, 0, 0, 1'b0, 0, 0, 4'b0010);
        #3;
        Reset = 1'b1;
        req = '0;
        q.delete();
        #1;
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        step(4'b1111, 0, 1, 2, 3, 1'b0, 0, 0, 4'b0001);
        idle(3);
        chk("scoreboard_empty", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
